// File: rtl/req_chan_arb.sv
// req_chan_arb: 4-manager round-robin arbiter for the request channel.
// Winner is registered into a 1-entry output stage; s_src tags origin.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   m_valid/m_ready     per-manager request handshake (one-hot ready)
//   m_id/m_addr/m_atop  packed per-manager fields, manager i at slot i
//   s_valid/s_ready     subordinate-side handshake
//   s_id/s_addr/s_atop  registered payload of the held request
//   s_src               index of the manager that issued it
module req_chan_arb #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          m_valid,
  output logic [3:0]          m_ready,
  input  logic [4*ID_W-1:0]   m_id,
  input  logic [4*ADDR_W-1:0] m_addr,
  input  logic [23:0]         m_atop,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [ID_W-1:0]     s_id,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [5:0]          s_atop,
  output logic [1:0]          s_src
);

  logic              out_v_q, out_v_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [5:0]        out_atop_q, out_atop_d;
  logic [1:0]        out_src_q, out_src_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;

  logic       load;
  logic       found;
  logic       grant;
  logic [1:0] win;
  logic [1:0] idx;

  // Stage accepts when empty or draining this cycle.
  assign load = ~out_v_q | s_ready;

  // First valid manager at or after rr_ptr, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    idx   = '0;
    for (int j = 0; j < 4; j++) begin
      idx = rr_ptr_q + 2'(j);
      if (!found && m_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant   = load & found;
  assign m_ready = grant ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    out_v_d    = out_v_q;
    out_id_d   = out_id_q;
    out_addr_d = out_addr_q;
    out_atop_d = out_atop_q;
    out_src_d  = out_src_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant) begin
      out_v_d    = 1'b1;
      out_id_d   = m_id[int'(win)*ID_W +: ID_W];
      out_addr_d = m_addr[int'(win)*ADDR_W +: ADDR_W];
      out_atop_d = m_atop[int'(win)*6 +: 6];
      out_src_d  = win;
      rr_ptr_d   = win + 2'd1;
    end else if (s_ready && out_v_q) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q    <= 1'b0;
      out_id_q   <= '0;
      out_addr_q <= '0;
      out_atop_q <= '0;
      out_src_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      out_v_q    <= out_v_d;
      out_id_q   <= out_id_d;
      out_addr_q <= out_addr_d;
      out_atop_q <= out_atop_d;
      out_src_q  <= out_src_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign s_valid = out_v_q;
  assign s_id    = out_id_q;
  assign s_addr  = out_addr_q;
  assign s_atop  = out_atop_q;
  assign s_src   = out_src_q;

endmodule

// File: tb/tb_req_chan_arb.sv
// tb_req_chan_arb: directed + random bench for req_chan_arb.
// Reference model tracks holding stage and fairness pointer abstractly.
module tb_req_chan_arb;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;

  logic                clk;
  logic                rst_n;
  logic [3:0]          m_valid;
  logic [3:0]          m_ready;
  logic [4*ID_W-1:0]   m_id;
  logic [4*ADDR_W-1:0] m_addr;
  logic [23:0]         m_atop;
  logic                s_valid;
  logic                s_ready;
  logic [ID_W-1:0]     s_id;
  logic [ADDR_W-1:0]   s_addr;
  logic [5:0]          s_atop;
  logic [1:0]          s_src;

  req_chan_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_id(m_id), .m_addr(m_addr), .m_atop(m_atop),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_id(s_id), .s_addr(s_addr), .s_atop(s_atop),
    .s_src(s_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Manager-side request state.
  bit              rv [4];
  logic [ID_W-1:0] rid [4];
  logic [31:0]     raddr [4];
  logic [5:0]      ratop [4];
  bit              rnd_mode = 0;

  // Reference model.
  bit          mo_v;
  logic [3:0]  mo_id;
  logic [31:0] mo_addr;
  logic [5:0]  mo_atop;
  logic [1:0]  mo_src;
  int          mo_ptr;

  logic [3:0]  last_rdy;
  logic [31:0] hold_addr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mo_v = 0; mo_id = '0; mo_addr = '0;
    mo_atop = '0; mo_src = '0; mo_ptr = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = rv[i];
      m_id[i*ID_W +: ID_W] = rid[i];
      m_addr[i*ADDR_W +: ADDR_W] = raddr[i];
      m_atop[i*6 +: 6] = ratop[i];
    end
  endtask

  // Winner: first requesting manager in rotation starting at the pointer.
  task automatic model_win(output bit g, output int k);
    g = 0; k = 0;
    if (!mo_v || s_ready) begin
      for (int j = 0; j < 4; j++) begin
        if (!g && rv[(mo_ptr + j) % 4]) begin
          g = 1; k = (mo_ptr + j) % 4;
        end
      end
    end
  endtask

  task automatic step();
    bit g;
    int k;
    logic [3:0] er;
    drive();
    @(negedge clk);
    model_win(g, k);
    er = g ? 4'(1 << k) : 4'b0;
    last_rdy = m_ready;
    chk("m_ready", 64'(m_ready), 64'(er));
    chk("s_valid", 64'(s_valid), 64'(mo_v));
    chk("s_id", 64'(s_id), 64'(mo_id));
    chk("s_addr", 64'(s_addr), 64'(mo_addr));
    chk("s_atop", 64'(s_atop), 64'(mo_atop));
    chk("s_src", 64'(s_src), 64'(mo_src));
    @(posedge clk);
    if (g) begin
      mo_v = 1; mo_id = rid[k]; mo_addr = raddr[k];
      mo_atop = ratop[k]; mo_src = 2'(k); mo_ptr = (k + 1) % 4;
      if (rnd_mode) rv[k] = 0;
    end else if (s_ready && mo_v) begin
      mo_v = 0;
    end
    #1;
  endtask

  task automatic set_all(input logic [3:0] v);
    for (int i = 0; i < 4; i++) rv[i] = v[i];
  endtask

  initial begin
    rst_n = 0; s_ready = 0;
    for (int i = 0; i < 4; i++) begin
      rv[i] = 0;
      rid[i] = 4'(i + 8);
      raddr[i] = 32'h100 * (i + 1);
      ratop[i] = 6'(i + 1);
    end
    drive();
    model_reset();
    #2;
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_s_src", 64'(s_src), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Round-robin with all four held valid.
    s_ready = 1;
    set_all(4'b1111);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_rdy", 64'(last_rdy), 64'(4'b0001 << (i % 4)));
      chk("rr_src", 64'(s_src), 64'(i % 4));
      chk("rr_sv", 64'(s_valid), 64'd1);
    end
    set_all(4'b0000);
    step();
    step();

    // Single manager 2.
    rid[2] = 4'h5; raddr[2] = 32'h0000_1000;
    set_all(4'b0100);
    step();
    chk("single_rdy", 64'(last_rdy), 64'h4);
    set_all(4'b0000);
    step();
    chk("single_rdy_off", 64'(last_rdy), 64'h0);

    // Idle drain: valid for exactly one cycle.
    chk("drain_sv0", 64'(s_valid), 64'd0);
    chk("drain_addr", 64'(s_addr), 64'h1000);
    step();

    // Wrap and skip from pointer 3.
    set_all(4'b0101);
    step();
    chk("wrap_rdy0", 64'(last_rdy), 64'h1);
    step();
    chk("wrap_rdy2", 64'(last_rdy), 64'h4);

    // Backpressure with 0011 pending, pointer 3.
    set_all(4'b0011);
    step();
    chk("bp_first", 64'(last_rdy), 64'h1);
    s_ready = 0;
    hold_addr = s_addr;
    repeat (5) begin
      step();
      chk("bp_rdy", 64'(last_rdy), 64'h0);
      chk("bp_addr", 64'(s_addr), 64'(hold_addr));
    end
    s_ready = 1;
    step();
    chk("bp_release", 64'(last_rdy), 64'h2);
    chk("bp_sv", 64'(s_valid), 64'd1);

    // Pointer 2 with 1011: winner 3, then wrap to 0.
    set_all(4'b1011);
    step();
    chk("p2_rdy3", 64'(last_rdy), 64'h8);
    step();
    chk("p2_rdy0", 64'(last_rdy), 64'h1);

    // Async reset mid-stream with a request held.
    set_all(4'b0000);
    drive();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_sv", 64'(s_valid), 64'd0);
    chk("mid_rst_src", 64'(s_src), 64'd0);
    chk("mid_rst_addr", 64'(s_addr), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    set_all(4'b1111);
    step();
    chk("post_rst_rdy", 64'(last_rdy), 64'h1);

    // Random traffic obeying the hold-until-ready rule.
    set_all(4'b0000);
    rnd_mode = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] && ($urandom_range(1, 0) == 1)) begin
          rv[i] = 1;
          rid[i] = 4'($urandom);
          raddr[i] = $urandom;
          ratop[i] = 6'($urandom);
        end
      end
      s_ready = ($urandom_range(9, 0) < 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
